// File: rtl/muldiv_if.sv
// Request/response bundle between pipeline control and the muldiv_unit.
// is_word exists only when MULDIV_WORD_EN is defined.
interface muldiv_if #(parameter int XLEN = 64);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      rd_in;
`ifdef MULDIV_WORD_EN
  logic            is_word;
`endif
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;
  logic            reg_write;

`ifdef MULDIV_WORD_EN
  modport master (output start, funct3, op_a, op_b, rd_in, is_word,
                  input  busy, done, result, rd_out, reg_write);
  modport slave  (input  start, funct3, op_a, op_b, rd_in, is_word,
                  output busy, done, result, rd_out, reg_write);
`else
  modport master (output start, funct3, op_a, op_b, rd_in,
                  input  busy, done, result, rd_out, reg_write);
  modport slave  (input  start, funct3, op_a, op_b, rd_in,
                  output busy, done, result, rd_out, reg_write);
`endif
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: shift-add multiply, restoring divide, one op in flight.
// Optional MULDIV_WORD_EN adds the is_word input for the RV64 *W operations.
module muldiv_unit #(
  parameter int XLEN = 64
) (
  input  logic    clk,
  input  logic    reset,
  muldiv_if.slave bus
);
  localparam int            CW         = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] FULL_ITERS = CW'(XLEN);
  localparam logic [CW-1:0] WORD_ITERS = CW'(32);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic            busy_r, done_r, reg_write_r;
  logic [XLEN-1:0] result_r;
  logic [4:0]      rd_r;

  logic [XLEN-1:0] acc, lo, opnd, fast_res;
  logic [2:0]      op;
  logic            word_op, fast, neg_ab, neg_rem;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] cneg(input logic [XLEN-1:0] v, input logic n);
    return n ? (~v + XLEN'(1)) : v;
  endfunction

  logic            word_sel, accept, is_div, a_signed, b_signed, sgn_a, sgn_b;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, fast_raw, fast_val;

`ifdef MULDIV_WORD_EN
  assign word_sel = bus.is_word;
`else
  assign word_sel = 1'b0;
`endif
  assign accept = (state == IDLE) && bus.start;

  // Operand conditioning at acceptance: extension, signs, magnitudes, fast-path result.
  always_comb begin
    is_div   = bus.funct3[2];
    a_signed = (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110) ||
               (!word_sel && ((bus.funct3 == 3'b001) || (bus.funct3 == 3'b010)));
    b_signed = (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110) ||
               (!word_sel && (bus.funct3 == 3'b001));
    if (word_sel) begin
      a_ext = a_signed ? sext32(bus.op_a[31:0]) : {{(XLEN-32){1'b0}}, bus.op_a[31:0]};
      b_ext = b_signed ? sext32(bus.op_b[31:0]) : {{(XLEN-32){1'b0}}, bus.op_b[31:0]};
    end else begin
      a_ext = bus.op_a;
      b_ext = bus.op_b;
    end
    sgn_a    = a_signed && a_ext[XLEN-1];
    sgn_b    = b_signed && b_ext[XLEN-1];
    mag_a    = cneg(a_ext, sgn_a);
    mag_b    = cneg(b_ext, sgn_b);
    div_zero = is_div && (b_ext == '0);
    div_ovf  = is_div && !bus.funct3[0] && (b_ext == '1) &&
               (a_ext == (word_sel ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}}));
    if (div_zero) fast_raw = bus.funct3[1] ? a_ext : '1;
    else          fast_raw = bus.funct3[1] ? '0 : a_ext;
    fast_val = word_sel ? sext32(fast_raw[31:0]) : fast_raw;
  end

  logic [XLEN:0]   sum, trial, diff;
  logic [XLEN-1:0] addend, step_acc, step_lo;

  // One iteration: {acc,lo} is the product/multiplier pair or the remainder/quotient pair.
  always_comb begin
    addend   = lo[0] ? opnd : '0;
    sum      = {1'b0, acc} + {1'b0, addend};
    trial    = {acc, lo[XLEN-1]};
    diff     = trial - {1'b0, opnd};
    step_acc = acc;
    step_lo  = lo;
    if (op[2]) begin
      if (!diff[XLEN]) begin
        step_acc = diff[XLEN-1:0];
        step_lo  = {lo[XLEN-2:0], 1'b1};
      end else begin
        step_acc = trial[XLEN-1:0];
        step_lo  = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      step_acc = sum[XLEN:1];
      step_lo  = {sum[0], lo[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op       <= bus.funct3;
      word_op  <= word_sel;
      fast     <= div_zero || div_ovf;
      fast_res <= fast_val;
      neg_ab   <= sgn_a ^ sgn_b;
      neg_rem  <= sgn_a;
      acc      <= '0;
      opnd     <= is_div ? mag_b : mag_a;
      // Word divides pre-shift the dividend so only its 32 live bits are iterated.
      if (is_div) lo <= word_sel ? {mag_a[XLEN-33:0], 32'b0} : mag_a;
      else        lo <= mag_b;
    end else if ((state == CALC) && (count != '0)) begin
      acc <= step_acc;
      lo  <= step_lo;
    end
  end

  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo, div_res, final_res;

  always_comb begin
    prod    = {acc, lo};
    prod_s  = neg_ab ? (~prod + (2*XLEN)'(1)) : prod;
    quo     = word_op ? {{(XLEN-32){1'b0}}, lo[31:0]} : lo;
    div_res = op[1] ? cneg(acc, neg_rem) : cneg(quo, neg_ab);
    if (fast)                final_res = fast_res;
    else if (op[2])          final_res = word_op ? sext32(div_res[31:0]) : div_res;
    else if (word_op)        final_res = sext32(lo[XLEN-1:XLEN-32]);
    else if (op[1:0] == 2'b00) final_res = prod_s[XLEN-1:0];
    else                     final_res = prod_s[2*XLEN-1:XLEN];
  end

  // Control FSM; a zero count in CALC is the finalisation edge that registers the result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      count       <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      reg_write_r <= 1'b0;
      result_r    <= '0;
      rd_r        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= CALC;
            busy_r <= 1'b1;
            rd_r   <= bus.rd_in;
            if (div_zero || div_ovf) count <= '0;
            else                     count <= word_sel ? WORD_ITERS : FULL_ITERS;
          end
        end
        CALC: begin
          if (count != '0) begin
            count <= count - CW'(1);
          end else begin
            state       <= DONE;
            done_r      <= 1'b1;
            reg_write_r <= 1'b1;
            result_r    <= final_res;
          end
        end
        DONE: begin
          state       <= IDLE;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
          reg_write_r <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.reg_write = reg_write_r;
  assign bus.result    = result_r;
  assign bus.rd_out    = rd_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed table-driven bench for muldiv_unit, plus abort and ignored-start sequences.
module tb_muldiv_unit;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  muldiv_if #(.XLEN(64)) bus ();

  muldiv_unit #(.XLEN(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    logic        w;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MNEG = 64'h8000_0000_0000_0000;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.op_a   = a;
    bus.op_b   = b;
    bus.rd_in  = rd;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.op_a   = 64'hDEAD_BEEF_0BAD_F00D;
    bus.op_b   = 64'h0123_4567_89AB_CDEF;
    bus.rd_in  = 5'd31;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while ((bus.done !== 1'b1) && (lat < 200)) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (bus.done !== 1'b1) lat = -1;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
`ifdef MULDIV_WORD_EN
    bus.is_word = v.w;
`endif
    issue(v.f3, v.a, v.b, v.rd);
    check({v.name, "_busy"}, 64'(bus.busy), 64'd1);
    wait_done(lat);
    check({v.name, "_latency"}, 64'(lat), 64'(v.lat));
    check({v.name, "_result"}, bus.result, v.exp);
    check({v.name, "_rd"}, 64'(bus.rd_out), 64'(v.rd));
    check({v.name, "_regwrite"}, 64'(bus.reg_write), 64'd1);
    @(posedge clk);
    #1;
    check({v.name, "_done_pulse"}, 64'({bus.done, bus.reg_write, bus.busy}), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat, lat2, pulses;
    checks = 0;
    errors = 0;

    vecs.push_back('{"mul_7xm3",      3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFEB, 65});
    vecs.push_back('{"mulhu_ones",    3'b011, ONES, ONES, 5'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 65});
    vecs.push_back('{"mulh_ones",     3'b001, ONES, ONES, 5'd7, 1'b0, 64'd0, 65});
    vecs.push_back('{"mulhsu_ones",   3'b010, ONES, ONES, 5'd8, 1'b0, ONES, 65});
    vecs.push_back('{"mulh_2pow64",   3'b001, 64'h4000_0000_0000_0000, 64'd4, 5'd9, 1'b0, 64'd1, 65});
    vecs.push_back('{"mul_big",       3'b000, 64'h1_2345_6789, 64'h10, 5'd10, 1'b0, 64'h12_3456_7890, 65});
    vecs.push_back('{"mulhu_zero",    3'b011, 64'd0, 64'h1234, 5'd11, 1'b0, 64'd0, 65});
    vecs.push_back('{"divu_by0",      3'b101, 64'd100, 64'd0, 5'd12, 1'b0, ONES, 1});
    vecs.push_back('{"remu_by0",      3'b111, 64'd100, 64'd0, 5'd13, 1'b0, 64'd100, 1});
    vecs.push_back('{"div_ovf",       3'b100, MNEG, ONES, 5'd14, 1'b0, MNEG, 1});
    vecs.push_back('{"rem_ovf",       3'b110, MNEG, ONES, 5'd15, 1'b0, 64'd0, 1});
    vecs.push_back('{"rem_m7_2",      3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd16, 1'b0, ONES, 65});
    vecs.push_back('{"div_m7_2",      3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd17, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 65});
    vecs.push_back('{"divu_100_7",    3'b101, 64'd100, 64'd7, 5'd18, 1'b0, 64'd14, 65});
    vecs.push_back('{"remu_100_7",    3'b111, 64'd100, 64'd7, 5'd19, 1'b0, 64'd2, 65});
    vecs.push_back('{"div_100_m7",    3'b100, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 5'd20, 1'b0, 64'hFFFF_FFFF_FFFF_FFF2, 65});
    vecs.push_back('{"rem_100_m7",    3'b110, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 5'd21, 1'b0, 64'd2, 65});
    vecs.push_back('{"div_m5_by0",    3'b100, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 5'd22, 1'b0, ONES, 1});
    vecs.push_back('{"rem_m5_by0",    3'b110, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 5'd23, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 1});
    vecs.push_back('{"div_mneg_1",    3'b100, MNEG, 64'd1, 5'd24, 1'b0, MNEG, 65});
    vecs.push_back('{"divu_ones_1",   3'b101, ONES, 64'd1, 5'd25, 1'b0, ONES, 65});
`ifdef MULDIV_WORD_EN
    vecs.push_back('{"divw_m7_2",     3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 33});
    vecs.push_back('{"mulw_wrap",     3'b000, 64'h8000_0000, 64'd2, 5'd2, 1'b1, 64'd0, 33});
    vecs.push_back('{"mulw_sext",     3'b000, 64'h7FFF_FFFF, 64'd2, 5'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 33});
    vecs.push_back('{"divuw_hi_junk", 3'b101, 64'h1234_5678_FFFF_FFFF, 64'h10, 5'd4, 1'b1, 64'h0FFF_FFFF, 33});
    vecs.push_back('{"divw_ovf",      3'b100, 64'h8000_0000, 64'hFFFF_FFFF, 5'd5, 1'b1, 64'hFFFF_FFFF_8000_0000, 1});
    vecs.push_back('{"remuw_by0",     3'b111, 64'd100, 64'h1_0000_0000, 5'd6, 1'b1, 64'd100, 1});
    vecs.push_back('{"mulhw_as_mul",  3'b001, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 33});
    bus.is_word = 1'b0;
`endif

    bus.start  = 1'b0;
    bus.funct3 = 3'b000;
    bus.op_a   = '0;
    bus.op_b   = '0;
    bus.rd_in  = '0;
    reset      = 1'b0;
    #1;
    check("reset_state", {bus.result, 59'(0), bus.busy, bus.done, bus.reg_write} == '0 ? 64'd0 : 64'd1, 64'd0);
    check("reset_rd", 64'(bus.rd_out), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Starts during CALC and DONE must be dropped without disturbing the op in flight.
    issue(3'b100, 64'd100, 64'd7, 5'd9);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = 3'b000;
    bus.op_a   = 64'd5;
    bus.op_b   = 64'd5;
    bus.rd_in  = 5'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(lat);
    check("ign_latency", 64'(lat < 0 ? -1 : lat + 10), 64'd65);
    check("ign_result", bus.result, 64'd14);
    check("ign_rd", 64'(bus.rd_out), 64'd9);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("ign_done_start_busy", 64'(bus.busy), 64'd0);
    check("ign_done_pulse", 64'(bus.done), 64'd0);
    issue(3'b000, 64'd5, 64'd5, 5'd4);
    wait_done(lat2);
    check("b2b_latency", 64'(lat2), 64'd65);
    check("b2b_result", bus.result, 64'd25);
    check("b2b_rd", 64'(bus.rd_out), 64'd4);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of CALC aborts without a done pulse.
    issue(3'b100, 64'd100, 64'd7, 5'd11);
    repeat (19) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_result", bus.result, 64'd0);
    check("abort_rd", 64'(bus.rd_out), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
    end
    check("abort_no_done", 64'(pulses), 64'd0);

    run_vec('{"post_abort_divu", 3'b101, 64'd100, 64'd7, 5'd12, 1'b0, 64'd14, 65});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV64M multiply/divide execute unit, directly downstream of the register file.
- Consumes the two register read operands (ReadData1/ReadData2) plus destination rd; returns a result, rd and a write strobe to the writeback path (WriteData/rd/RegWrite).
- Multi-cycle, one operation in flight; start/busy/done handshake with pipeline control.

Parameters:
XLEN, 64, operand/result width; iteration count for full-width ops.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low; reset=0 clears all state immediately.
start  input  1  request; sampled only in IDLE.
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
op_a  input  XLEN  rs1 operand (ReadData1).
op_b  input  XLEN  rs2 operand (ReadData2).
rd_in  input  5  destination register.
is_word  input  1  RV64 *W op select; present only with MULDIV_WORD_EN.
busy  output  1  high in CALC and DONE.
done  output  1  one-cycle pulse; result/rd_out valid.
result  output  XLEN  operation result; held until next accepted start.
rd_out  output  5  captured rd_in.
reg_write  output  1  equals done; drives register-file RegWrite.

Behaviour:
- Reset (reset=0, async): state=IDLE; busy=0, done=0, reg_write=0, result=0, rd_out=0, counter=0. Aborts any op in flight; no done pulse for it.
- States: IDLE, CALC, DONE.
- IDLE: start=1 at edge E0 latches op_a, op_b, funct3, rd_in, is_word, and operand signs/magnitudes.
  - Div fast path: divide by zero or signed overflow goes to DONE.
  - Otherwise goes to CALC, counter=N (N=XLEN, or 32 for word ops).
- CALC: one iteration per edge.
  - Multiply: shift-add on magnitudes, 2*XLEN-bit product.
  - Divide: restoring, one quotient bit per edge on magnitudes.
  - Counter decrements each edge; at the edge where it reaches 0, go to DONE with result registered.
- DONE: done=reg_write=1 for exactly one cycle; next edge goes to IDLE.
- Latency: full path, done high in the cycle after edge E(N+1), i.e. N+1 edges after E0. Fast path, done high after E1.
- start while busy=1 (CALC or DONE) is ignored; no queueing. Back-to-back: start can be accepted the cycle after done.
- Result selection and sign handling:
  - MUL: low XLEN bits of the product.
  - MULH: high XLEN, signed x signed.
  - MULHSU: high XLEN, signed x unsigned.
  - MULHU: high XLEN, unsigned.
  - Negative product is the two's complement of the full 2*XLEN-bit magnitude product before slicing.
  - DIV/REM round toward zero. Remainder takes the dividend's sign; quotient is negated when operand signs differ.
- Boundary cases:
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = op_a.
  - Signed overflow (op_a=most-negative, op_b=-1): DIV = op_a; REM = 0.
- Outputs change only on clock edges (except async reset). Operand inputs are don't-care after E0.

Optional Feature:
MULDIV_WORD_EN
- Defined:
  - is_word port exists. is_word=1 selects MULW/DIVW/DIVUW/REMW/REMUW; MULH* with is_word=1 behaves as MUL.
  - Operands are the low 32 bits of op_a/op_b, sign- or zero-extended per op; 32 iterations.
  - The 32-bit result is sign-extended to XLEN. Fast-path checks use 32-bit values (divisor low 32 bits = 0; 0x80000000 / -1).
- Undefined: no is_word port; all ops are full XLEN.

Test Plan:
- MUL op_a=7, op_b=0xFFFFFFFFFFFFFFFD (-3) -> done after 65 edges, result=0xFFFFFFFFFFFFFFEB, rd_out=rd_in, reg_write pulse 1 cycle.
- MULHU op_a=op_b=0xFFFFFFFFFFFFFFFF -> result=0xFFFFFFFFFFFFFFFE; MULH same operands -> 0.
- DIVU op_a=100, op_b=0 -> done after 1 edge, result=0xFFFFFFFFFFFFFFFF. REMU same operands -> result=100.
- DIV op_a=0x8000000000000000, op_b=-1 -> result=0x8000000000000000 (fast path). REM same operands -> 0. REM op_a=-7, op_b=2 -> result=-1.
- Start DIV 100/7, pulse start with other operands at cycle 10 and in the DONE cycle -> ignored, result=14; reassert start the next cycle -> accepted.
- Drive reset=0 mid-CALC (cycle 20) -> busy/done/result=0 immediately, no done pulse. With MULDIV_WORD_EN: DIVW 0xFFFFFFFF_FFFFFFF9 / 2 -> result=0xFFFFFFFFFFFFFFFD after 33 edges.
